// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the transmitter now and by the receiver later.
//   tx_state_e  : transmit frame FSM states
//   OVERSAMPLE  : baud oversample ratio (ticks per bit)
//   UART_DIV_W  : default divisor width
//   parity_bit(): parity over a data byte, even or odd
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned UART_DIV_W = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Bits of data above the frame width must be zero on entry.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// 16x oversample baud prescaler, shared between UART TX and RX.
// Ports:
//   clk, rst_n : UART clock, asynchronous active-low reset
//   clr        : synchronous clear; reloads the prescaler so the next tick is
//                exactly divisor cycles away
//   divisor    : baud divisor; 0 behaves as 1; sampled only at reload
//   tick16     : one-cycle pulse at 16x the baud rate (registered)
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_W = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DIV_W-1:0] divisor,
  output logic             tick16
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] reload;
  logic             tick_q;

  always_comb begin
    reload = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    if (clr || cnt_q == '0) begin
      cnt_d = reload;
    end else begin
      cnt_d = cnt_q - DIV_W'(1);
    end
  end

  // The tick is the registered "counter is zero" flag: it matches cnt_q == 0
  // everywhere except straight out of reset, where it stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == '0);
    end
  end

  assign tick16 = tick_q;

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: valid/ready byte input, serialised onto txd as
// start + DATA_BITS (LSB first) + optional parity + 1 or 2 stop bits.
// Build option: define UART_TX_PARITY_EN to honour parity_en/parity_odd;
// without it those ports are ignored and frames carry no parity bit.
// Ports:
//   clk, rst_n         : UART clock, asynchronous active-low reset
//   divisor            : baud = f_clk / (16 * divisor)
//   tx_data, tx_valid  : byte to send and its valid
//   tx_ready           : high in idle; a byte is taken on valid && ready
//   parity_en/odd      : parity enable and sense, latched per frame
//   two_stop           : two stop bits, latched per frame
//   txd                : registered serial output, idle high
//   busy               : frame in progress
//   tick16             : 16x oversample pulse, exported for debug/RX reuse
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = UART_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] divisor,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  output logic             txd,
  output logic             busy,
  output logic             tick16
);

  localparam logic [3:0] OsLast  = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BitLast = 3'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [3:0]           os_q, os_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop2_q, stop2_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 txd_q, txd_d;
  logic                 two_stop_q;
  logic                 accept;
  logic                 bit_end;
  logic                 par_en_eff;
  logic                 par_bit;

  uart_baud_gen #(
    .DIV_W (DIV_W)
  ) u_baud_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .divisor (divisor),
    .tick16  (tick16)
  );

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_q;
  logic [7:0] data_masked;

  assign data_masked = 8'(tx_data[DATA_BITS-1:0]);

  // Parity is computed at accept time so the frame is independent of later
  // changes on tx_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else if (accept) begin
      par_en_q <= parity_en;
      par_q    <= parity_bit(data_masked, parity_odd);
    end
  end

  assign par_en_eff = par_en_q;
  assign par_bit    = par_q;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
  assign par_en_eff        = 1'b0;
  assign par_bit           = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      two_stop_q <= 1'b0;
    end else if (accept) begin
      two_stop_q <= two_stop;
    end
  end

  assign bit_end = tick16 && (os_q == OsLast);

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    stop2_d = stop2_q;
    shreg_d = shreg_q;
    txd_d   = txd_q;
    accept  = 1'b0;

    if (state_q != StIdle && tick16) begin
      os_d = os_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          accept  = 1'b1;
          state_d = StStart;
          txd_d   = 1'b0;
          os_d    = '0;
          bit_d   = '0;
          stop2_d = 1'b0;
          shreg_d = tx_data[DATA_BITS-1:0];
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          txd_d   = shreg_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == BitLast) begin
            if (par_en_eff) begin
              state_d = StParity;
              txd_d   = par_bit;
            end else begin
              state_d = StStop;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shreg_d = shreg_q >> 1;
            txd_d   = shreg_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          txd_d   = 1'b1;
        end
      end
      StStop: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // Second stop bit reuses the oversample counter for another 16 ticks.
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      os_q    <= '0;
      bit_q   <= '0;
      stop2_q <= 1'b0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      stop2_q <= stop2_d;
      shreg_q <= shreg_d;
      txd_q   <= txd_d;
    end
  end

  assign txd      = txd_q;
  assign tx_ready = (state_q == StIdle);
  assign busy     = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

  logic        clk;
  logic        rst_n;
  logic [15:0] divisor;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        parity_en;
  logic        parity_odd;
  logic        two_stop;
  logic        txd;
  logic        busy;
  logic        tick16;

  int n_cmp;
  int n_bad;

  uart_tx_core #(
    .DATA_BITS (8),
    .DIV_W     (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .divisor    (divisor),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .txd        (txd),
    .busy       (busy),
    .tick16     (tick16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Call just after a negedge. Sends one byte and checks every txd cycle of
  // the frame against a waveform built from the arguments. Returns just after
  // the negedge at which tx_ready is seen again. With hold set, tx_valid is
  // left high for a following back-to-back call.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic pe,
                           input logic po, input logic ts, input int d, input bit hold);
    int         dd;
    int         bl;
    int         nb;
    int         idx;
    int         n;
    int         errs;
    int         k;
    int         b;
    bit         done;
    logic [11:0] exp_bits;
    logic [11:0] mid;
    logic [7:0]  dec;
    logic        pe_eff;

`ifdef UART_TX_PARITY_EN
    pe_eff = pe;
`else
    pe_eff = 1'b0;
`endif
    dd = (d == 0) ? 1 : d;
    bl = 16 * dd;
    exp_bits = '1;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = data[i];
    idx = 9;
    if (pe_eff) begin
      exp_bits[idx] = (^data) ^ po;
      idx++;
    end
    nb = idx + 1 + (ts ? 1 : 0);
    mid = '0;

    divisor    = 16'(d);
    tx_data    = data;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    tx_valid   = 1'b1;

    k = 0;
    while (!tx_ready && k < 20000) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_ready_before"}, 32'(tx_ready), 32'd1);
    check_eq({tag, "_idle_txd"}, 32'(txd), 32'd1);

    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
    // Scramble the inputs: the frame in flight must not follow them.
    tx_data    = ~data;
    parity_en  = ~pe;
    parity_odd = ~po;
    two_stop   = ~ts;

    n = 0;
    errs = 0;
    done = 1'b0;
    while (!done && n < 20000) begin
      @(negedge clk);
      if (tx_ready) begin
        done = 1'b1;
      end else begin
        b = n / bl;
        if (b >= nb || busy !== 1'b1) errs++;
        else if (txd !== exp_bits[b]) errs++;
        if ((n % bl) == (bl / 2) && b < 12) mid[b] = txd;
        n++;
      end
    end
    check_eq({tag, "_done"}, 32'(done), 32'd1);
    check_eq({tag, "_len"}, 32'(n), 32'(nb * bl));
    check_eq({tag, "_wave_errs"}, 32'(errs), 32'd0);
    for (int i = 0; i < 8; i++) dec[i] = mid[1+i];
    check_eq({tag, "_decoded"}, 32'(dec), 32'(data));
  endtask

  int errs_idle;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    rst_n      = 1'b0;
    divisor    = 16'd1;
    tx_data    = 8'h00;
    tx_valid   = 1'b0;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    two_stop   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tick16", 32'(tick16), 32'd0);
    rst_n = 1'b1;

    errs_idle = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || tx_ready !== 1'b1) errs_idle++;
    end
    check_eq("idle_1000", 32'(errs_idle), 32'd0);

    // 8N1, divisor 1: 160-cycle frame
    run_frame("d1_55", 8'h55, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    // Parity, divisor 3 (528 cycles with parity, 480 without)
    run_frame("d3_55_even", 8'h55, 1'b1, 1'b0, 1'b0, 3, 1'b0);
    run_frame("d3_55_odd", 8'h55, 1'b1, 1'b1, 1'b0, 3, 1'b0);

    // Two stop bits: 176 cycles
    run_frame("ts_ff", 8'hFF, 1'b0, 1'b0, 1'b1, 1, 1'b0);

    // Back-to-back with tx_valid held high
    run_frame("b2b_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    run_frame("b2b_3c", 8'h3C, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    // Divisor 0 behaves as 1
    run_frame("d0_0f", 8'h0F, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Reset in the middle of a frame of zeros
    divisor  = 16'd1;
    tx_data  = 8'h00;
    two_stop = 1'b0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (60) @(negedge clk);
    check_eq("mid_txd_low", 32'(txd), 32'd0);
    check_eq("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_txd", 32'(txd), 32'd1);
    check_eq("async_rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("after_rst_81", 8'h81, 1'b0, 1'b0, 1'b0, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
